// File: rtl/arm_pkg.sv
// rtl/arm_pkg.sv - shared ARM pipeline types and constants
// Purpose: word width, PC increment and the fetch queue entry layout.
// Ports: none (package).
package arm_pkg;

    localparam int          WORD_W  = 32;
    localparam logic [31:0] PC_STEP = 32'd4;

    typedef struct packed {
        logic [WORD_W-1:0] instruction;
        logic [WORD_W-1:0] pc_plus4;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_stage_if.sv
// rtl/fetch_stage_if.sv - fetch stage bus: instruction memory, redirect and decode handshake
// Purpose: groups the fetch stage's memory, branch and decode-side signals.
// Ports (modport fetch = fetch stage side):
//   imem_pc out, imem_instruction in, branch_taken in, branch_address in,
//   id_valid out, id_ready in, id_instruction out, id_pc_plus4 out.
// Modport env is the mirror image (memory, execute and decode side).
interface fetch_stage_if;
    import arm_pkg::*;

    logic [WORD_W-1:0] imem_pc;
    logic [WORD_W-1:0] imem_instruction;
    logic              branch_taken;
    logic [WORD_W-1:0] branch_address;
    logic              id_valid;
    logic              id_ready;
    logic [WORD_W-1:0] id_instruction;
    logic [WORD_W-1:0] id_pc_plus4;

    modport fetch (
        output imem_pc,
        input  imem_instruction,
        input  branch_taken,
        input  branch_address,
        output id_valid,
        input  id_ready,
        output id_instruction,
        output id_pc_plus4
    );

    modport env (
        input  imem_pc,
        output imem_instruction,
        output branch_taken,
        output branch_address,
        input  id_valid,
        output id_ready,
        input  id_instruction,
        input  id_pc_plus4
    );

endinterface

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - in-order circular buffer of fetched instructions
// Purpose: DEPTH-entry queue with push, pop and flush; head is a registered entry.
// Ports:
//   clk, rst   clock, synchronous active-high reset (clears storage too)
//   push, pop  write at tail / advance head
//   flush      empty the queue; overrides push, a same-cycle pop is simply absorbed
//   wr_data    entry written on push
//   head       entry at the read pointer
//   count      occupancy 0..DEPTH
//   full       count == DEPTH
module fetch_queue
    import arm_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  fetch_entry_t               wr_data,
    output fetch_entry_t               head,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;

    assign head = mem[rd_ptr];
    assign full = (count == CNT_W'(DEPTH));

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            // When full with a pop, wr_ptr == rd_ptr: the entry being
            // delivered this cycle is overwritten at the edge, which is safe.
            if (push) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - ARM instruction fetch stage (PC, fetch queue, redirect)
// Purpose: owns the PC, fetches from combinational instruction memory into a
// small in-order queue, hands entries to decode over valid/ready, and flushes
// on branch redirects from execute.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   bus (fetch_stage_if)     imem_pc/imem_instruction, branch_taken/branch_address,
//                            id_valid/id_ready/id_instruction/id_pc_plus4
//   perf_fetch_count         pushes since reset (only with IF_PERF_CNT_EN)
//   perf_redirect_count      branch_taken cycles since reset (only with IF_PERF_CNT_EN)
// Build option: IF_PERF_CNT_EN adds the two performance counters.
module fetch_stage
    import arm_pkg::*;
#(
    parameter logic [31:0] PC_RESET = 32'd0,
    parameter int          DEPTH    = 2
) (
    input  logic               clk,
    input  logic               rst,
    fetch_stage_if.fetch       bus
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0]        perf_fetch_count,
    output logic [31:0]        perf_redirect_count
`endif
);

    localparam int CNT_W = $clog2(DEPTH+1);

    logic [WORD_W-1:0] pc;
    logic              push;
    logic              pop;
    logic              full;
    logic [CNT_W-1:0]  count;
    fetch_entry_t      wr_entry;
    fetch_entry_t      head_entry;

    assign bus.imem_pc        = pc;
    assign bus.id_valid       = (count != '0);
    assign bus.id_instruction = head_entry.instruction;
    assign bus.id_pc_plus4    = head_entry.pc_plus4;

    assign pop  = bus.id_valid & bus.id_ready;
    // A pop frees a slot in the same cycle, so a full queue still accepts a
    // fetch when decode is draining it.
    assign push = !bus.branch_taken & (!full | pop);

    assign wr_entry.instruction = bus.imem_instruction;
    assign wr_entry.pc_plus4    = pc + PC_STEP;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= PC_RESET;
        end else if (bus.branch_taken) begin
            pc <= {bus.branch_address[WORD_W-1:2], 2'b00};
        end else if (push) begin
            pc <= pc + PC_STEP;
        end
    end

    fetch_queue #(
        .DEPTH (DEPTH)
    ) u_queue (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .pop     (pop),
        .flush   (bus.branch_taken),
        .wr_data (wr_entry),
        .head    (head_entry),
        .count   (count),
        .full    (full)
    );

`ifdef IF_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetch_count    <= '0;
            perf_redirect_count <= '0;
        end else begin
            if (push) begin
                perf_fetch_count <= perf_fetch_count + 32'd1;
            end
            if (bus.branch_taken) begin
                perf_redirect_count <= perf_redirect_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - scoreboard bench for fetch_stage
module tb_fetch_stage;

    localparam logic [31:0] K = 32'hE1A0_0000;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    fetch_stage_if bus1 ();
    fetch_stage_if bus2 ();

    // Memory model: instruction word encodes its own address.
    assign bus1.imem_instruction = bus1.imem_pc ^ K;
    assign bus2.imem_instruction = bus2.imem_pc ^ K;

`ifdef IF_PERF_CNT_EN
    logic [31:0] pf1, pr1, pf2, pr2;
`endif

    fetch_stage #(.PC_RESET(32'd0), .DEPTH(2)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .bus                 (bus1)
`ifdef IF_PERF_CNT_EN
        ,
        .perf_fetch_count    (pf1),
        .perf_redirect_count (pr1)
`endif
    );

    fetch_stage #(.PC_RESET(32'hFFFF_FFFC), .DEPTH(2)) dut_wrap (
        .clk                 (clk),
        .rst                 (rst),
        .bus                 (bus2)
`ifdef IF_PERF_CNT_EN
        ,
        .perf_fetch_count    (pf2),
        .perf_redirect_count (pr2)
`endif
    );

    int vec_cnt = 0;
    int err_cnt = 0;
    int pop_count = 0;
    logic [31:0] exp_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every accepted head must match the next expected entry.
    always @(negedge clk) begin
        if (!rst && bus1.id_valid === 1'b1 && bus1.id_ready === 1'b1) begin
            logic [31:0] e;
            pop_count++;
            if (exp_q.size() == 0) begin
                vec_cnt++;
                err_cnt++;
                $display("FAIL unexpected_pop: got pc_plus4 %h expected no delivery", bus1.id_pc_plus4);
            end else begin
                e = exp_q.pop_front();
                check("pop_pc_plus4", bus1.id_pc_plus4, e);
                check("pop_instruction", bus1.id_instruction, (e - 32'd4) ^ K);
            end
        end
    end

    initial begin
        int p0;
        rst = 1'b1;
        bus1.id_ready = 1'b0;
        bus1.branch_taken = 1'b0;
        bus1.branch_address = '0;
        bus2.id_ready = 1'b0;
        bus2.branch_taken = 1'b0;
        bus2.branch_address = '0;
        step();
        step();

        // Reset state
        check("rst_imem_pc", bus1.imem_pc, 32'd0);
        check("rst_id_valid", {31'd0, bus1.id_valid}, 32'd0);
        check("rst_id_instruction", bus1.id_instruction, 32'd0);
        check("rst_id_pc_plus4", bus1.id_pc_plus4, 32'd0);
        check("wrap_rst_imem_pc", bus2.imem_pc, 32'hFFFF_FFFC);

        rst = 1'b0;
        check("first_imem_pc", bus1.imem_pc, 32'd0);
        step();

        // PC wrap instance
        check("wrap_imem_pc", bus2.imem_pc, 32'h0000_0000);
        check("wrap_id_valid", {31'd0, bus2.id_valid}, 32'd1);
        check("wrap_id_pc_plus4", bus2.id_pc_plus4, 32'h0000_0000);
        check("wrap_id_instruction", bus2.id_instruction, 32'hFFFF_FFFC ^ K);

        // Fetch-to-decode latency
        check("first_id_valid", {31'd0, bus1.id_valid}, 32'd1);
        check("first_id_pc_plus4", bus1.id_pc_plus4, 32'd4);

        // Decode stalled: queue fills, PC holds at 8
        repeat (4) step();
        check("stall_imem_pc", bus1.imem_pc, 32'd8);
        check("stall_id_valid", {31'd0, bus1.id_valid}, 32'd1);

        // Release: 0,4,8 then sustained one per cycle
        for (int a = 4; a <= 24; a += 4) exp_q.push_back(32'(a));
        p0 = pop_count;
        bus1.id_ready = 1'b1;
        repeat (6) step();
        bus1.id_ready = 1'b0;
        check("throughput_pops", 32'(pop_count - p0), 32'd6);
        check("after_stream_imem_pc", bus1.imem_pc, 32'd32);

        // Redirect while full
        bus1.branch_taken = 1'b1;
        bus1.branch_address = 32'h0000_0093;
        step();
        bus1.branch_taken = 1'b0;
        check("redir_imem_pc", bus1.imem_pc, 32'h90);
        check("redir_id_valid", {31'd0, bus1.id_valid}, 32'd0);
        step();
        check("redir_head_valid", {31'd0, bus1.id_valid}, 32'd1);
        check("redir_head_pc_plus4", bus1.id_pc_plus4, 32'h94);
        check("redir_head_instruction", bus1.id_instruction, 32'h90 ^ K);
        exp_q.push_back(32'h94);
        exp_q.push_back(32'h98);
        bus1.id_ready = 1'b1;
        step();
        step();
        bus1.id_ready = 1'b0;

        // Redirect with a same-cycle pop
        exp_q.push_back(32'h9C);
        bus1.id_ready = 1'b1;
        bus1.branch_taken = 1'b1;
        bus1.branch_address = 32'h0000_0200;
        step();
        bus1.branch_taken = 1'b0;
        check("pop_redir_imem_pc", bus1.imem_pc, 32'h200);
        check("pop_redir_id_valid", {31'd0, bus1.id_valid}, 32'd0);
        exp_q.push_back(32'h204);
        exp_q.push_back(32'h208);
        exp_q.push_back(32'h20C);
        repeat (4) step();
        bus1.id_ready = 1'b0;
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        // Fill, then reset together with a redirect
        step();
        check("refill_imem_pc", bus1.imem_pc, 32'h214);
        check("refill_id_pc_plus4", bus1.id_pc_plus4, 32'h210);
`ifdef IF_PERF_CNT_EN
        check("perf_fetch_count", pf1, 32'd16);
        check("perf_redirect_count", pr1, 32'd2);
`endif
        rst = 1'b1;
        bus1.branch_taken = 1'b1;
        bus1.branch_address = 32'h0000_0400;
        step();
        check("mid_rst_id_valid", {31'd0, bus1.id_valid}, 32'd0);
        check("mid_rst_imem_pc", bus1.imem_pc, 32'd0);
        check("mid_rst_id_instruction", bus1.id_instruction, 32'd0);
        check("mid_rst_id_pc_plus4", bus1.id_pc_plus4, 32'd0);
`ifdef IF_PERF_CNT_EN
        check("mid_rst_perf_fetch", pf1, 32'd0);
        check("mid_rst_perf_redirect", pr1, 32'd0);
`endif
        rst = 1'b0;
        bus1.branch_taken = 1'b0;
        step();
        check("post_rst_id_valid", {31'd0, bus1.id_valid}, 32'd1);
        check("post_rst_id_pc_plus4", bus1.id_pc_plus4, 32'd4);

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
